// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared types, defaults and cycle-count helpers for the ultrasonic ranger
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_e;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_CM_W       = 10;
    localparam int DEF_CLK_PER_US = 50;
    localparam int DEF_TRIG_US    = 10;
    localparam int DEF_US_PER_CM  = 58;
    localparam int DEF_MAX_CM     = 400;
    localparam int DEF_SLOT_US    = 60000;

    // Derived cycle counts are computed in 64 bits so large parameter products cannot wrap.
    function automatic longint unsigned trig_cyc(longint unsigned trig_us, longint unsigned clk_per_us);
        return trig_us * clk_per_us;
    endfunction

    function automatic longint unsigned cm_cyc(longint unsigned us_per_cm, longint unsigned clk_per_us);
        return us_per_cm * clk_per_us;
    endfunction

    function automatic longint unsigned wait_limit_cyc(longint unsigned trig_us, longint unsigned max_cm,
                                                       longint unsigned us_per_cm, longint unsigned clk_per_us);
        return (trig_us + max_cm * us_per_cm) * clk_per_us;
    endfunction

    function automatic longint unsigned slot_cyc(longint unsigned slot_us, longint unsigned clk_per_us);
        return slot_us * clk_per_us;
    endfunction

    // Width of a counter that holds 0..n-1, never narrower than one bit.
    function automatic int cnt_w(longint unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - two-flop echo synchroniser with rise/fall pulses
module echo_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two flops for metastability, a third copy to detect edges on the synced level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/multi_ultrasonic_ranger.sv
// rtl/multi_ultrasonic_ranger.sv - round-robin multi-channel HC-SR04 ranging sequencer
module multi_ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int CM_W       = DEF_CM_W,
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int TRIG_US    = DEF_TRIG_US,
    parameter int US_PER_CM  = DEF_US_PER_CM,
    parameter int MAX_CM     = DEF_MAX_CM,
    parameter int SLOT_US    = DEF_SLOT_US
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic                     ENABLE,
    input  logic [CHANNELS-1:0]      ECH,
    output logic [CHANNELS-1:0]      TR,
    output logic [CHANNELS*CM_W-1:0] CM,
    output logic [CHANNELS-1:0]      VALID,
    output logic [CHANNELS-1:0]      TIMEOUT,
    output logic                     SAMPLE_STB,
    output logic [2:0]               SAMPLE_CH
);

    localparam longint unsigned TRIG_CYC       = trig_cyc(64'(TRIG_US), 64'(CLK_PER_US));
    localparam longint unsigned CM_CYC         = cm_cyc(64'(US_PER_CM), 64'(CLK_PER_US));
    localparam longint unsigned WAIT_LIMIT_CYC = wait_limit_cyc(64'(TRIG_US), 64'(MAX_CM),
                                                                64'(US_PER_CM), 64'(CLK_PER_US));
    localparam longint unsigned SLOT_CYC       = slot_cyc(64'(SLOT_US), 64'(CLK_PER_US));

    localparam int SLOT_W = cnt_w(SLOT_CYC);
    localparam int PS_W   = cnt_w(CM_CYC);
    localparam int CH_W   = cnt_w(64'(CHANNELS));

    localparam logic [SLOT_W-1:0] SLOT_TRIG_LAST = SLOT_W'(TRIG_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_WAIT_END  = SLOT_W'(WAIT_LIMIT_CYC);
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(SLOT_CYC - 1);
    localparam logic [PS_W-1:0]   PS_LAST        = PS_W'(CM_CYC - 1);
    localparam logic [CM_W-1:0]   CM_LIMIT       = CM_W'(MAX_CM);
    localparam logic [CH_W-1:0]   CH_LAST        = CH_W'(CHANNELS - 1);

    state_e                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [PS_W-1:0]          presc_q, presc_d;
    logic [CM_W-1:0]          cnt_q, cnt_d;
    logic [CHANNELS*CM_W-1:0] cm_q, cm_d;
    logic [CHANNELS-1:0]      valid_q, valid_d;
    logic [CHANNELS-1:0]      timeout_q, timeout_d;
    logic                     stb_q, stb_d;
    logic [2:0]               sch_q, sch_d;
    logic [CHANNELS-1:0]      rise_w, fall_w;
    logic [CHANNELS-1:0]      tr_w;
    logic                     rise_sel, fall_sel;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        echo_sync u_echo_sync (
            .clk_i  (CLOCK),
            .rst_ni (RESET_N),
            .echo_i (ECH[g]),
            .rise_o (rise_w[g]),
            .fall_o (fall_w[g])
        );
    end

    assign rise_sel = rise_w[ch_q];
    assign fall_sel = fall_w[ch_q];

    // Next-state logic: slot sequencing, echo measurement and result capture.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        slot_d    = slot_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        cm_d      = cm_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        stb_d     = 1'b0;
        sch_d     = sch_q;
        if (state_q != IDLE) begin
            slot_d = slot_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                slot_d = '0;
                if (ENABLE) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (slot_q == SLOT_TRIG_LAST) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise_sel) begin
                    // The edge cycle itself is the first echo-high cycle, so it is counted.
                    state_d = MEASURE;
                    if (CM_CYC == 1) begin
                        cnt_d   = CM_W'(1);
                        presc_d = '0;
                    end else begin
                        cnt_d   = '0;
                        presc_d = PS_W'(1);
                    end
                end else if (slot_q == SLOT_WAIT_END) begin
                    timeout_d[ch_q] = 1'b1;
                    stb_d           = 1'b1;
                    sch_d           = 3'(ch_q);
                    state_d         = GAP;
                end
            end
            MEASURE: begin
                if (presc_q == PS_LAST) begin
                    presc_d = '0;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // A falling edge on the limit cycle still counts as a good sample.
                if (fall_sel) begin
                    cm_d[int'(ch_q)*CM_W +: CM_W] = cnt_q;
                    valid_d[ch_q]   = 1'b1;
                    timeout_d[ch_q] = 1'b0;
                    stb_d           = 1'b1;
                    sch_d           = 3'(ch_q);
                    state_d         = GAP;
                end else if (cnt_q == CM_LIMIT) begin
                    timeout_d[ch_q] = 1'b1;
                    stb_d           = 1'b1;
                    sch_d           = 3'(ch_q);
                    state_d         = GAP;
                end
            end
            GAP: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    state_d = ENABLE ? TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Trigger is decoded from registered state so reset drops it without waiting for a clock.
    always_comb begin
        tr_w = '0;
        if (state_q == TRIG) begin
            tr_w[ch_q] = 1'b1;
        end
    end

    // State and result registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            slot_q    <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            cm_q      <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
            stb_q     <= 1'b0;
            sch_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            slot_q    <= slot_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            cm_q      <= cm_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stb_q     <= stb_d;
            sch_q     <= sch_d;
        end
    end

    assign TR         = tr_w;
    assign CM         = cm_q;
    assign VALID      = valid_q;
    assign TIMEOUT    = timeout_q;
    assign SAMPLE_STB = stb_q;
    assign SAMPLE_CH  = sch_q;

endmodule

// File: tb/tb_multi_ultrasonic_ranger.sv
// tb/tb_multi_ultrasonic_ranger.sv - self-checking bench for multi_ultrasonic_ranger
module tb_multi_ultrasonic_ranger;

    localparam int NCH        = 2;
    localparam int CMW        = 10;
    localparam int TRIG_CYC   = 3;
    localparam int CM_CYC     = 2;
    localparam int MAX_CM     = 20;
    localparam int WAIT_LIMIT = 43;
    localparam int SLOT_CYC   = 100;
    localparam int SYNC_LAT   = 2;

    logic               CLOCK = 1'b0;
    logic               RESET_N;
    logic               ENABLE;
    logic [NCH-1:0]     ECH;
    logic [NCH-1:0]     TR;
    logic [NCH*CMW-1:0] CM;
    logic [NCH-1:0]     VALID;
    logic [NCH-1:0]     TIMEOUT;
    logic               SAMPLE_STB;
    logic [2:0]         SAMPLE_CH;

    int checks = 0;
    int failures = 0;

    int       slot_k = -1;
    int       cur_ch = 0;
    int       exp_stb_k = -1;
    bit       exp_to = 1'b0;
    int       exp_cm = 0;
    int       m_cm [NCH];
    bit [1:0] m_valid = '0;
    bit [1:0] m_to = '0;
    bit [1:0] pre_high = '0;
    int       last_stb_k = -1;
    int       tr_cnt = 0;
    logic [1:0] c_etr;
    logic       c_estb;

    multi_ultrasonic_ranger #(
        .CHANNELS   (NCH),
        .CM_W       (CMW),
        .CLK_PER_US (1),
        .TRIG_US    (3),
        .US_PER_CM  (2),
        .MAX_CM     (MAX_CM),
        .SLOT_US    (SLOT_CYC)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .ECH        (ECH),
        .TR         (TR),
        .CM         (CM),
        .VALID      (VALID),
        .TIMEOUT    (TIMEOUT),
        .SAMPLE_STB (SAMPLE_STB),
        .SAMPLE_CH  (SAMPLE_CH)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome of one slot from the echo pulse placement (slot-relative pin cycles).
    function automatic void predict(input int rise_k, input int width, input bit stuck,
                                    output int stb_k, output bit to, output int cm);
        int edge_k;
        edge_k = rise_k + SYNC_LAT;
        cm = 0;
        if (stuck || width == 0 || edge_k < TRIG_CYC || edge_k > WAIT_LIMIT) begin
            stb_k = WAIT_LIMIT + 1;
            to    = 1'b1;
        end else if (width > CM_CYC * MAX_CM) begin
            stb_k = edge_k + CM_CYC * MAX_CM + 1;
            to    = 1'b1;
        end else begin
            stb_k = edge_k + width + 1;
            to    = 1'b0;
            cm    = width / CM_CYC;
        end
    endfunction

    task automatic drive_echo(input int ch, input int k, input int rise_k, input int width, input bit stuck);
        int o;
        o = 1 - ch;
        ECH[ch] = stuck || (width > 0 && k >= rise_k && k < rise_k + width);
        ECH[o]  = pre_high[o] || (k >= 20 && k < 60 && k[2]);
    endtask

    // Called one step after the edge that enters TRIG for this slot.
    task automatic run_slot(input int ch, input int rise_k, input int width, input bit stuck, input int drop_k);
        int p_stb;
        bit p_to;
        int p_cm;
        predict(rise_k, width, stuck, p_stb, p_to, p_cm);
        cur_ch    = ch;
        exp_stb_k = p_stb;
        exp_to    = p_to;
        exp_cm    = p_cm;
        slot_k    = 0;
        for (int k = 0; k < SLOT_CYC; k++) begin
            drive_echo(ch, k, rise_k, width, stuck);
            if (k == drop_k) ENABLE = 1'b0;
            @(posedge CLOCK);
            #1;
            slot_k = k + 1;
        end
        if (!ENABLE) slot_k = -1;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        m_cm[0] = 0;
        m_cm[1] = 0;
        forever begin
            @(negedge CLOCK);
            if (RESET_N === 1'b1) begin
                c_etr  = '0;
                c_estb = 1'b0;
                if (slot_k >= 0 && slot_k < SLOT_CYC) begin
                    if (slot_k < TRIG_CYC) c_etr[cur_ch] = 1'b1;
                    if (slot_k == exp_stb_k) begin
                        c_estb = 1'b1;
                        if (exp_to) begin
                            m_to[cur_ch] = 1'b1;
                        end else begin
                            m_cm[cur_ch]    = exp_cm;
                            m_valid[cur_ch] = 1'b1;
                            m_to[cur_ch]    = 1'b0;
                        end
                    end
                end
                if (TR[0] === 1'b1) tr_cnt++;
                if (SAMPLE_STB === 1'b1) last_stb_k = slot_k;
                chk("tr", 32'(TR), 32'(c_etr));
                chk("sample_stb", 32'(SAMPLE_STB), 32'(c_estb));
                if (c_estb) chk("sample_ch", 32'(SAMPLE_CH), 32'(cur_ch));
                chk("cm0", 32'(CM[CMW-1:0]), 32'(m_cm[0]));
                chk("cm1", 32'(CM[2*CMW-1:CMW]), 32'(m_cm[1]));
                chk("valid", 32'(VALID), 32'(m_valid));
                chk("timeout", 32'(TIMEOUT), 32'(m_to));
            end
        end
    end

    initial begin
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        ECH     = '0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_tr", 32'(TR), 0);
        chk("rst_cm", 32'(CM), 0);
        chk("rst_valid", 32'(VALID), 0);
        chk("rst_timeout", 32'(TIMEOUT), 0);
        chk("rst_stb", 32'(SAMPLE_STB), 0);
        chk("rst_sch", 32'(SAMPLE_CH), 0);
        RESET_N = 1'b1;
        repeat (4) begin @(posedge CLOCK); #1; end

        // A: ch0 echo 5 cycles after trigger ends, 24 cycles wide
        ENABLE = 1'b1;
        @(posedge CLOCK); #1;
        tr_cnt = 0;
        run_slot(0, 8, 24, 1'b0, -1);
        chk("A_cm0", 32'(CM[CMW-1:0]), 12);
        chk("A_valid", 32'(VALID), 32'b01);
        chk("A_stb_k", 32'(last_stb_k), 35);
        chk("A_tr_cycles", 32'(tr_cnt), 3);

        // B: ch1 no echo
        run_slot(1, 0, 0, 1'b0, -1);
        chk("B_timeout", 32'(TIMEOUT), 32'b10);
        chk("B_valid", 32'(VALID), 32'b01);
        chk("B_cm1", 32'(CM[2*CMW-1:CMW]), 0);
        chk("B_stb_k", 32'(last_stb_k), 44);

        // C: ch0 held high 60 cycles; ch1 pin goes high ahead of its slot
        pre_high = 2'b10;
        run_slot(0, 10, 60, 1'b0, -1);
        chk("C_cm0", 32'(CM[CMW-1:0]), 12);
        chk("C_timeout", 32'(TIMEOUT), 32'b11);
        chk("C_stb_k", 32'(last_stb_k), 53);

        // D: ch1 stuck high through its slot
        run_slot(1, 0, 0, 1'b1, -1);
        pre_high = 2'b00;
        chk("D_timeout", 32'(TIMEOUT), 32'b11);
        chk("D_valid", 32'(VALID), 32'b01);
        chk("D_stb_k", 32'(last_stb_k), 44);

        // E: ch0 echo of exactly MAX_CM, ENABLE dropped while measuring
        run_slot(0, 6, 40, 1'b0, 20);
        chk("E_cm0", 32'(CM[CMW-1:0]), 20);
        chk("E_timeout", 32'(TIMEOUT), 32'b10);
        chk("E_stb_k", 32'(last_stb_k), 49);
        repeat (6) begin @(posedge CLOCK); #1; end

        // F: re-enable resumes on ch1, shortest echo
        ENABLE = 1'b1;
        @(posedge CLOCK); #1;
        run_slot(1, 4, 1, 1'b0, -1);
        chk("F_cm1", 32'(CM[2*CMW-1:CMW]), 0);
        chk("F_valid", 32'(VALID), 32'b11);
        chk("F_timeout", 32'(TIMEOUT), 32'b00);
        chk("F_stb_k", 32'(last_stb_k), 8);

        // G: reset pulse during ch0 trigger
        cur_ch    = 0;
        exp_stb_k = -5;
        slot_k    = 0;
        ECH       = '0;
        @(posedge CLOCK); #1;
        slot_k = 1;
        #2;
        RESET_N = 1'b0;
        slot_k  = -1;
        m_cm[0] = 0;
        m_cm[1] = 0;
        m_valid = '0;
        m_to    = '0;
        #1;
        chk("G_tr_async", 32'(TR), 0);
        chk("G_cm", 32'(CM), 0);
        chk("G_valid", 32'(VALID), 0);
        chk("G_timeout", 32'(TIMEOUT), 0);
        chk("G_stb", 32'(SAMPLE_STB), 0);
        chk("G_sch", 32'(SAMPLE_CH), 0);
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLOCK); #1;

        // H: restart on ch0 after reset
        run_slot(0, 8, 24, 1'b0, -1);
        chk("H_cm0", 32'(CM[CMW-1:0]), 12);
        chk("H_valid", 32'(VALID), 32'b01);
        chk("H_stb_k", 32'(last_stb_k), 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
